// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC select and IF/ID register.
// A fetch-address fault parks the stage in HALT until reset.
//
// state | meaning
// RUN   | fetching; PC advances unless stalled
// HALT  | fetch fault seen; PC frozen, ID fed nops until reset
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] branch,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_addr,
  input  logic [31:0] instr_IF,
  output logic [31:0] pc_IF,
  output logic [31:0] pc_a4,
  output logic [31:0] instr_ID,
  output logic [31:0] pc_ID,
  output logic        bd_ID,
  output logic        fetch_err,
  output logic        halted
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [32:0] PC_LIMIT = {1'b0, PC_RESET} + 33'(4 * IM_WORDS);

  state_t      state;
  logic [31:0] npc;

  assign pc_a4     = pc_IF + 32'd4;
  assign fetch_err = (pc_IF[1:0] != 2'b00) || (pc_IF < PC_RESET) ||
                     ({1'b0, pc_IF} >= PC_LIMIT);

  always_comb begin
    npc = pc_a4;
    case (npc_sel)
      2'd0: npc = pc_a4;
      2'd1: npc = branch;
      2'd2: npc = {pc_ID[31:28], instr_index, 2'b00};
      2'd3: npc = jr_addr;
      default: npc = pc_a4;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      pc_IF    <= PC_RESET;
      instr_ID <= 32'd0;
      pc_ID    <= 32'd0;
      bd_ID    <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!stall) begin
            if (fetch_err) begin
              // faulting address stays on pc_IF for post-mortem inspection
              state    <= HALT;
              halted   <= 1'b1;
              instr_ID <= 32'd0;
              pc_ID    <= pc_IF;
              bd_ID    <= 1'b0;
            end else begin
              pc_IF    <= npc;
              instr_ID <= instr_IF;
              pc_ID    <= pc_IF;
              bd_ID    <= (npc_sel != 2'd0);
            end
          end
        end
        HALT: begin
          instr_ID <= 32'd0;
          bd_ID    <= 1'b0;
        end
        default: begin
          state  <= HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the P5 five-stage MIPS pipeline: owns the program counter, selects the next PC and holds the IF/ID pipeline register. It consumes the branch-target bus produced by the ID-stage comparator, sequential PC+4, jump targets and jr register values. It feeds `instr_ID`, `pc_ID` and the current `pc_a4` to decode and the comparator. Branch delay slots are architectural, so the stage never flushes on a taken branch. A fetch-address fault parks the stage in a sticky halt state.

## Interface
- `PC_RESET`, 32'h0000_3000, PC value loaded on reset.
- `IM_WORDS`, 1024, instruction memory depth in words; legal fetch range is [PC_RESET, PC_RESET+4*IM_WORDS).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; takes effect immediately, independent of `clk`.
- `stall`  in  1  hazard-unit stall; freezes PC and IF/ID.
- `npc_sel`  in  2  next-PC select from ID decode: 0 = PC+4, 1 = `branch`, 2 = jump, 3 = jr.
- `branch`  in  32  comparator output (target if taken, else its PC+4 input).
- `instr_index`  in  26  j/jal index field of `instr_ID`.
- `jr_addr`  in  32  forwarded rs value for jr/jalr.
- `instr_IF`  in  32  instruction-memory read data at `pc_IF` (combinational).
- `pc_IF`  out  32  current fetch address, to instruction memory.
- `pc_a4`  out  32  `pc_IF + 4`, combinational, to comparator.
- `instr_ID`  out  32  IF/ID instruction.
- `pc_ID`  out  32  IF/ID PC.
- `bd_ID`  out  1  IF/ID instruction is a delay slot.
- `fetch_err`  out  1  combinational: `pc_IF` misaligned or out of range.
- `halted`  out  1  stage is in HALT.

## Operation
- Two-state FSM: RUN, HALT. Reset enters RUN.
- Next PC, modulo 2^32 with no overflow detection:
  - `npc_sel`=0: `pc_IF+4`.
  - `npc_sel`=1: `branch`.
  - `npc_sel`=2: {`pc_ID[31:28]`, `instr_index`, 2'b00}.
  - `npc_sel`=3: `jr_addr`.
- `fetch_err` = (`pc_IF[1:0]`!=0) OR `pc_IF` < PC_RESET OR `pc_IF` >= PC_RESET+4*IM_WORDS. The upper bound is computed in 33 bits so it cannot wrap.
- RUN, `stall`=0, `fetch_err`=0:
  - `pc_IF` <= next PC.
  - `instr_ID` <= `instr_IF`.
  - `pc_ID` <= `pc_IF`.
  - `bd_ID` <= (`npc_sel`!=0).
- RUN, `stall`=1: all registers hold, including `bd_ID`. `npc_sel` is ignored. The error check is deferred until the first unstalled cycle.
- RUN, `stall`=0, `fetch_err`=1:
  - Transition to HALT.
  - `pc_IF` holds the faulting address.
  - `instr_ID` <= 0 (nop), `pc_ID` <= `pc_IF`, `bd_ID` <= 0.
- HALT: `pc_IF` frozen. Each edge loads `instr_ID` <= 0 and `bd_ID` <= 0. `stall` and `npc_sel` are ignored. Only reset exits HALT.
- `halted` = (state==HALT), registered.

## Timing
- Reset values, applied asynchronously: `pc_IF`=PC_RESET, `instr_ID`=0, `pc_ID`=0, `bd_ID`=0, state RUN, `halted`=0.
- Fetch-to-ID latency is 1 cycle: an instruction at `pc_IF` in cycle n appears on `instr_ID` in cycle n+1.
- Branch/jump resolution happens in ID. The instruction fetched in the same cycle is the delay slot and enters ID with `bd_ID`=1. The target is fetched the following cycle, with no bubble.
- `pc_a4` and `fetch_err` are combinational from `pc_IF`. Every other output is registered.
- Reset asserted mid-stall or in HALT overrides everything in the same instant. On the first edge after deassertion, fetch proceeds from PC_RESET.
- `stall` and `npc_sel` are sampled only at the rising edge. The stage expects them to be settled before the edge; their values between edges have no effect.

## Test plan
- Reset, then 3 unstalled edges with `npc_sel`=0 and `instr_IF`=32'h3401_0001:
  - `pc_IF` = 3000 → 3004 → 3008 → 300C.
  - `instr_ID`=34010001 with `pc_ID` = 3008 after the third edge.
  - `bd_ID`=0 throughout.
- Taken branch:
  - Drive `pc_IF`=3010, `pc_ID`=300C, `npc_sel`=1, `branch`=3020, then 1 edge.
  - Expect `pc_IF`=3020, `pc_ID`=3010, `bd_ID`=1.
  - Next edge with `npc_sel`=0: expect `pc_IF`=3024, `bd_ID`=0.
- Jump/jr:
  - `pc_ID`=3004, `instr_index`=26'h0000C08, `npc_sel`=2 → `pc_IF`=3020 after the edge.
  - `npc_sel`=3, `jr_addr`=3100 → `pc_IF`=3100.
- Stall: hold `stall`=1 for 3 edges with `npc_sel`=1, `branch`=3FFC.
  - PC and IF/ID unchanged across all 3 edges.
  - Release `stall`: the next edge applies the current `npc_sel`.
- Fault:
  - `npc_sel`=3, `jr_addr`=3002 → `pc_IF`=3002 and `fetch_err`=1.
  - Next edge: `halted`=1, `instr_ID`=0, `pc_ID`=3002.
  - 5 further edges with varied `npc_sel`: `pc_IF` stays 3002.
  - Assert `reset` between edges: `pc_IF`=3000 and `halted`=0 immediately.
- Range fault: with IM_WORDS=1024, jump to 3FFC executes normally. The following PC 4000 raises `fetch_err` and the stage halts on the next edge.
